// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply or restoring divide, one bit per cycle over XLEN
// cycles, followed by a sign-fix cycle and a result-publish cycle.
// Optional build macro: MULDIV_EARLY_OUT_EN (zero-operand early completion).
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Two's complement negation, modulo the operand width.
    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Two's complement negation of a full double-width product.
    function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

    // Control state
    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;

    // Datapath state (no reset needed; always loaded before use)
    logic [2:0]        r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [XLEN-1:0]   r_m;      // multiplicand (mul) or divisor (div), magnitude
    logic [2*XLEN-1:0] r_acc;    // mul: {hi, multiplier/lo}; div: {unused, quotient}
    logic [XLEN-1:0]   r_rem;    // partial remainder, always < divisor
    logic [XLEN-1:0]   r_res;    // result waiting to be published in DONE

    // Issue-side decode
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_accept;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    // Iteration datapath
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_acc;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_div_acc;

    // Sign-fix datapath
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remd;
    logic [XLEN-1:0]   w_fix_res;

    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                        (op_i == OP_DIV)  || (op_i == OP_REM);
    assign w_b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_sa       = w_a_signed && opr_a[XLEN-1];
    assign w_sb       = w_b_signed && opr_b[XLEN-1];
    assign w_a_abs    = w_sa ? f_neg(opr_a) : opr_a;
    assign w_b_abs    = w_sb ? f_neg(opr_b) : opr_b;
    assign w_ovf      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                        (opr_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (opr_b == {XLEN{1'b1}});

    // Resolve operand combinations that need no iteration.
    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (op_i[2] && (opr_b == '0)) begin
            w_special     = 1'b1;
            w_special_res = op_i[1] ? opr_a : {XLEN{1'b1}};
        end else if (w_ovf) begin
            w_special     = 1'b1;
            w_special_res = op_i[1] ? '0 : opr_a;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (!op_i[2] && ((opr_a == '0) || (opr_b == '0))) begin
            w_special     = 1'b1;
            w_special_res = '0;
        end else if (op_i[2] && (opr_a == '0)) begin
            w_special     = 1'b1;
            w_special_res = '0;
`endif
        end
    end

    // One iteration step of both the shift-add multiply and restoring divide.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
        w_mul_acc = {w_sum, r_acc[XLEN-1:1]};
        w_shift   = {r_rem, r_acc[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_m};
        if (!w_diff[XLEN]) begin
            w_div_rem = w_diff[XLEN-1:0];
            w_div_acc = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_div_rem = w_shift[XLEN-1:0];
            w_div_acc = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and output selection for the FIX cycle.
    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? f_neg2(r_acc) : r_acc;
        w_quot = (r_sign_a ^ r_sign_b) ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_remd = r_sign_a ? f_neg(r_rem) : r_rem;
        case (r_op)
            OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_fix_res = w_quot;
            default:                      w_fix_res = w_remd;
        endcase
    end

    // FSM, iteration counter and published result/strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_special) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                            r_cnt   <= CW'(XLEN-1);
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    r_state <= flush_i ? S_IDLE : S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    if (!flush_i) begin
                        r_valid  <= 1'b1;
                        r_result <= r_res;
                    end
                end
            endcase
        end
    end

    // Operand capture, iteration registers and pending result.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    r_op     <= op_i;
                    r_sign_a <= w_sa;
                    r_sign_b <= w_sb;
                    r_res    <= w_special_res;
                    r_rem    <= '0;
                    if (op_i[2]) begin
                        r_m   <= w_b_abs;
                        r_acc <= {{XLEN{1'b0}}, w_a_abs};
                    end else begin
                        r_m   <= w_a_abs;
                        r_acc <= {{XLEN{1'b0}}, w_b_abs};
                    end
                end
            end
            S_CALC: begin
                if (r_op[2]) begin
                    r_acc <= w_div_acc;
                    r_rem <= w_div_rem;
                end else begin
                    r_acc <= w_mul_acc;
                end
            end
            S_FIX: begin
                r_res <= w_fix_res;
            end
            default: begin
            end
        endcase
    end

    assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX) || w_accept;
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: vector table with scoreboard plus hand-written
// flush / start-conflict / reset sequences.
module tb_muldiv_seq;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int FULL = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = FULL;
`endif

    logic        clk, rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] opr_a, opr_b;
    logic        busy_o, valid_o;
    logic [31:0] result_o;

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opr_a(opr_a), .opr_b(opr_b), .flush_i(flush_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input string nm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = lat; v.nm = nm;
        vecs.push_back(v);
    endtask

    // Scoreboard: every valid_o must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got result %h with no request outstanding", result_o);
            end else begin
                chk("scoreboard_result", result_o, sb.pop_front());
            end
        end
    end

    // Launch one operation and measure latency and busy duration.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int lat, input bit hold, input string nm);
        int n;
        int nbusy;
        bit got;
        op_i = op; opr_a = a; opr_b = b; start_i = 1'b1;
        sb.push_back(e);
        #1;
        chk({nm, "_busy_at_start"}, {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
        if (!hold) start_i = 1'b0;
        n = 0; nbusy = 0; got = 1'b0;
        while (n < 100) begin
            if (valid_o) begin
                got = 1'b1;
                break;
            end
            if (busy_o) nbusy++;
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no valid_o within %0d cycles", nm, n);
        end else begin
            chk({nm, "_latency"}, n, lat);
            chk({nm, "_busy_cycles"}, nbusy, (lat == 1) ? 0 : lat - 1);
            last_res = e;
        end
    endtask

    // Abort a DIVU 100/7 by pulsing flush_i while the FSM sits k edges after accept.
    task automatic flush_at(input int k, input string nm);
        op_i = DIVU; opr_a = 32'd100; opr_b = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk({nm, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({nm, "_valid"}, {31'd0, valid_o}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk({nm, "_result_hold"}, result_o, last_res);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = '0; opr_a = '0; opr_b = '0;

        add(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL, "mulhu_max");
        add(MUL,    32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, FULL, "mul_neg3x7");
        add(MULH,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, FULL, "mulh_neg3x7");
        add(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, FULL, "mulhsu_neg1x2");
        add(MULH,   32'h80000000, 32'h80000000, 32'h40000000, FULL, "mulh_min_sq");
        add(MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, FULL, "mulhsu_min_umax");
        add(MULHU,  32'h80000000, 32'd4,        32'd2,        FULL, "mulhu_shift");
        add(MUL,    32'h12345678, 32'h10,       32'h23456780, FULL, "mul_x16");
        add(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, FULL, "div_neg7_2");
        add(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, FULL, "rem_neg7_2");
        add(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, FULL, "div_7_neg2");
        add(REM,    32'd7,        32'hFFFFFFFE, 32'd1,        FULL, "rem_7_neg2");
        add(DIV,    32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2,        FULL, "div_neg8_neg3");
        add(REM,    32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, FULL, "rem_neg8_neg3");
        add(DIVU,   32'd100,      32'd7,        32'd14,       FULL, "divu_100_7");
        add(REMU,   32'd100,      32'd7,        32'd2,        FULL, "remu_100_7");
        add(DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, FULL, "divu_max_1");
        add(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,    "div_by_zero");
        add(REMU,   32'd5,        32'd0,        32'd5,        1,    "remu_by_zero");
        add(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,    "div_overflow");
        add(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,    "rem_overflow");
        add(MUL,    32'd0,        32'h12345,    32'd0,        EO_LAT, "mul_zero_a");
        add(MULHU,  32'h12345,    32'd0,        32'd0,        EO_LAT, "mulhu_zero_b");
        add(DIVU,   32'd0,        32'd5,        32'd0,        EO_LAT, "divu_zero_a");
        add(REM,    32'd0,        32'd5,        32'd0,        EO_LAT, "rem_zero_a");

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0, vecs[i].nm);

        // Flush in CALC, FIX and DONE, then a normal operation.
        flush_at(10, "flush_calc");
        flush_at(32, "flush_fix");
        flush_at(33, "flush_done");
        run_op(DIVU, 32'd100, 32'd7, 32'd14, FULL, 1'b0, "after_flush");

        // start_i held through the whole operation: exactly one result.
        run_op(MUL, 32'd6, 32'd7, 32'd42, FULL, 1'b1, "start_held");
        repeat (40) @(posedge clk);
        #1;

        // start_i and flush_i together in IDLE: nothing launched.
        op_i = DIVU; opr_a = 32'd9; opr_b = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("start_flush_busy_comb", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        chk("start_flush_busy_next", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0; flush_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("start_flush_result_hold", result_o, last_res);

        // Reset mid-operation discards it and clears the result.
        op_i = MULHU; opr_a = 32'hFFFFFFFF; opr_b = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_busy", {31'd0, busy_o}, 32'd0);
        chk("midreset_valid", {31'd0, valid_o}, 32'd0);
        chk("midreset_result", result_o, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        last_res = 32'd0;
        run_op(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FULL, 1'b0, "after_reset");

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
